// File: rtl/analyzer_pkg.sv
// Shared types and helpers for the logic analyzer capture engine.
package analyzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Bit offset of channel ch inside a flat multi-channel bus.
  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module capture_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 64,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write and registered read; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/logic_analyzer_core.sv
// Multi-channel circular capture engine with pattern/external trigger and
// trigger-relative chronological readout.
module logic_analyzer_core
  import analyzer_pkg::*;
#(
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 64,
  localparam int unsigned ADDR_W    = $clog2(DEPTH),
  localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  input  logic                         arm,
  input  logic                         abort,
  input  logic                         trig_ext,
  input  logic                         trig_src,
  input  logic [CH_W-1:0]              trig_ch,
  input  logic [DATA_WIDTH-1:0]        trig_mask,
  input  logic [DATA_WIDTH-1:0]        trig_value,
  input  logic [ADDR_W-1:0]            post_count,
  input  logic                         rd_en,
  input  logic [CH_W-1:0]              rd_ch,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic [1:0]                   state,
  output logic [ADDR_W-1:0]            trig_index
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     post_cnt;
  logic [CNT_W-1:0]      fill_cnt;
  logic [DATA_WIDTH-1:0] trig_sample;
  logic                  hit;
  logic                  qual;
  logic                  accept;
  logic                  we;
  logic [ADDR_W-1:0]     rd_phys;
  logic [DATA_WIDTH-1:0] ram_q [NUM_CH];
  logic                  rd_en_q;
  logic [CH_W-1:0]       rd_ch_q;

  assign state = state_q;

  // Trigger compare and pre-trigger history qualification.
  always_comb begin
    trig_sample = din[ch_lsb(32'(trig_ch), DATA_WIDTH) +: DATA_WIDTH];
    hit         = trig_src ? trig_ext
                           : ((trig_sample & trig_mask) == (trig_value & trig_mask));
    qual        = fill_cnt >= (CNT_W'(DEPTH - 1) - CNT_W'(post_count));
    accept      = (state_q == ST_ARMED) && hit && qual;
    we          = (state_q == ST_ARMED) || (state_q == ST_POST);
    rd_phys     = wr_ptr + rd_addr;
  end

  // Next-state logic; abort overrides everything, arm only from IDLE/DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (arm) state_d = ST_ARMED;
      ST_ARMED:         if (accept) state_d = (post_count == '0) ? ST_DONE : ST_POST;
      ST_POST:          if (post_cnt == ADDR_W'(1)) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Write pointer, fill level, post-trigger countdown and trigger index.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      trig_index <= '0;
    end else if (abort) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
    end else begin
      if (arm && (state_q == ST_IDLE || state_q == ST_DONE)) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
      end
      if (we) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (fill_cnt != CNT_W'(DEPTH)) fill_cnt <= fill_cnt + CNT_W'(1);
      end
      if (accept) begin
        post_cnt   <= post_count;
        trig_index <= ADDR_W'(DEPTH - 1) - post_count;
      end else if (state_q == ST_POST) begin
        post_cnt <= post_cnt - ADDR_W'(1);
      end
    end
  end

  // One buffer per channel sharing write pointer, write enable and read address.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    capture_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_ram (
      .clk    (clk),
      .we     (we),
      .wr_addr(wr_ptr),
      .wr_data(din[ch_lsb(g, DATA_WIDTH) +: DATA_WIDTH]),
      .re     (rd_en),
      .rd_addr(rd_phys),
      .rd_data(ram_q[g])
    );
  end

  // Second read stage: channel mux register and valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q  <= 1'b0;
      rd_ch_q  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_en_q  <= rd_en;
      rd_ch_q  <= rd_ch;
      rd_valid <= rd_en_q;
      if (rd_en_q) rd_data <= ram_q[rd_ch_q];
    end
  end

endmodule
